// File: rtl/drum_tumble_controller.sv
// ---------------------------------------------------------------------------
// drum_tumble_controller
//
// Drum motor sequencer. Sits between the washing machine cycle controller and
// the motor driver. Starting from IDLE it ramps the commanded speed up to a
// latched target. In tumble mode it runs for run_ticks, ramps down, pauses
// and reverses direction. In spin mode it holds speed until stopped.
// Vibration during spin triggers a rebalance: ramp down, fixed pause, ramp up.
// After too many rebalances it latches a fault.
//
// Ports
//   i_clk                 system clock, rising edge
//   i_reset_n             asynchronous active-low reset
//   i_enable              run request (level)
//   i_mode                00 stop, 01 tumble, 10 spin, 11 stop
//   i_target_rpm          target speed, latched at start
//   i_run_ticks           tumble run ticks per direction (0 acts as 1)
//   i_pause_ticks         tumble pause ticks between directions
//   i_motor_speed_sensor  tachometer RPM
//   i_vibration_sensor    excessive vibration level
//   o_motor_on            motor driver enable
//   o_motor_dir           0 = clockwise, 1 = counter-clockwise
//   o_speed_cmd           commanded RPM
//   o_at_speed            running and sensor within SPEED_TOL of command
//   o_busy                not idle
//   o_fault               rebalance limit exceeded
// ---------------------------------------------------------------------------
module drum_tumble_controller #(
    parameter int TICK_DIV    = 1,
    parameter int RAMP_STEP   = 10,
    parameter int SPEED_TOL   = 10,
    parameter int REBAL_PAUSE = 30,
    parameter int MAX_REBAL   = 3
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic [1:0] i_mode,
    input  logic [9:0] i_target_rpm,
    input  logic [7:0] i_run_ticks,
    input  logic [7:0] i_pause_ticks,
    input  logic [9:0] i_motor_speed_sensor,
    input  logic       i_vibration_sensor,
    output logic       o_motor_on,
    output logic       o_motor_dir,
    output logic [9:0] o_speed_cmd,
    output logic       o_at_speed,
    output logic       o_busy,
    output logic       o_fault
);

    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int VCW = $clog2(MAX_REBAL + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_UP,
        S_RUN,
        S_RAMP_DOWN,
        S_PAUSE,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        R_STOP,
        R_REVERSE,
        R_REBAL
    } reason_t;

    state_t         r_state,   w_state;
    reason_t        r_reason,  w_reason;
    logic [9:0]     r_speed,   w_speed;
    logic [7:0]     r_phase,   w_phase;
    logic           r_dir,     w_dir;
    logic [VCW-1:0] r_vibCnt,  w_vibCnt;
    logic [9:0]     r_target,  w_target;
    logic [7:0]     r_runTicks, w_runTicks;
    logic [7:0]     r_pauseTicks, w_pauseTicks;
    logic           r_spin,    w_spin;
    logic [TCW-1:0] r_tickCnt;

    logic           w_tick;
    logic [10:0]    w_upSum;
    logic [9:0]     w_upNext;
    logic [9:0]     w_downNext;
    logic [VCW-1:0] w_vibInc;
    logic [9:0]     w_speedDiff;

    // Free-running tick divider; the tick is its terminal count.
    assign w_tick = (r_tickCnt == TCW'(TICK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tickCnt <= '0;
        end else if (w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + TCW'(1);
        end
    end

    // Ramp arithmetic: the up step is one bit wider so it cannot wrap before
    // clamping to the target; the down step saturates at zero.
    assign w_upSum    = {1'b0, r_speed} + 11'(RAMP_STEP);
    assign w_upNext   = (w_upSum >= {1'b0, r_target}) ? r_target : w_upSum[9:0];
    assign w_downNext = (r_speed > 10'(RAMP_STEP)) ? (r_speed - 10'(RAMP_STEP)) : 10'd0;
    assign w_vibInc   = r_vibCnt + VCW'(1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_reason     <= R_STOP;
            r_speed      <= '0;
            r_phase      <= '0;
            r_dir        <= 1'b0;
            r_vibCnt     <= '0;
            r_target     <= '0;
            r_runTicks   <= '0;
            r_pauseTicks <= '0;
            r_spin       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_reason     <= w_reason;
            r_speed      <= w_speed;
            r_phase      <= w_phase;
            r_dir        <= w_dir;
            r_vibCnt     <= w_vibCnt;
            r_target     <= w_target;
            r_runTicks   <= w_runTicks;
            r_pauseTicks <= w_pauseTicks;
            r_spin       <= w_spin;
        end
    end

    // Stop and vibration react every clock; ramp and phase counters only on
    // ticks. A stop request outranks vibration, so the vibration count is
    // left alone when both arrive together.
    always_comb begin
        w_state      = r_state;
        w_reason     = r_reason;
        w_speed      = r_speed;
        w_phase      = r_phase;
        w_dir        = r_dir;
        w_vibCnt     = r_vibCnt;
        w_target     = r_target;
        w_runTicks   = r_runTicks;
        w_pauseTicks = r_pauseTicks;
        w_spin       = r_spin;

        case (r_state)
            S_IDLE: begin
                if (i_enable && (i_mode == 2'b01 || i_mode == 2'b10) && (i_target_rpm != 10'd0)) begin
                    w_target     = i_target_rpm;
                    w_runTicks   = (i_run_ticks == 8'd0) ? 8'd1 : i_run_ticks;
                    w_pauseTicks = i_pause_ticks;
                    w_spin       = (i_mode == 2'b10);
                    w_vibCnt     = '0;
                    w_dir        = 1'b0;
                    w_speed      = '0;
                    w_state      = S_RAMP_UP;
                end
            end

            S_RAMP_UP, S_RUN: begin
                if (!i_enable) begin
                    w_reason = R_STOP;
                    w_state  = S_RAMP_DOWN;
                end else if (r_spin && i_vibration_sensor) begin
                    w_vibCnt = w_vibInc;
                    if (w_vibInc < VCW'(MAX_REBAL)) begin
                        w_reason = R_REBAL;
                        w_state  = S_RAMP_DOWN;
                    end else begin
                        w_state = S_FAULT;
                        w_speed = '0;
                    end
                end else if (w_tick) begin
                    if (r_state == S_RAMP_UP) begin
                        w_speed = w_upNext;
                        if (w_upNext == r_target) begin
                            w_state = S_RUN;
                            w_phase = r_runTicks;
                        end
                    end else if (!r_spin) begin
                        // Tumble run: leave on the tick that would reach zero.
                        if (r_phase <= 8'd1) begin
                            w_reason = R_REVERSE;
                            w_state  = S_RAMP_DOWN;
                        end else begin
                            w_phase = r_phase - 8'd1;
                        end
                    end
                end
            end

            S_RAMP_DOWN: begin
                if (!i_enable) begin
                    w_reason = R_STOP;
                end
                if (w_tick) begin
                    w_speed = w_downNext;
                    if (w_downNext == 10'd0) begin
                        if (w_reason == R_STOP) begin
                            w_state = S_IDLE;
                        end else begin
                            w_state = S_PAUSE;
                            w_phase = (w_reason == R_REVERSE) ? r_pauseTicks : 8'(REBAL_PAUSE);
                        end
                    end
                end
            end

            S_PAUSE: begin
                if (!i_enable) begin
                    w_state = S_IDLE;
                end else if (w_tick) begin
                    // A zero-length pause also exits on its first tick.
                    if (r_phase <= 8'd1) begin
                        if (r_reason == R_REVERSE) begin
                            w_dir = ~r_dir;
                        end
                        w_state = S_RAMP_UP;
                    end else begin
                        w_phase = r_phase - 8'd1;
                    end
                end
            end

            S_FAULT: begin
                if (!i_enable) begin
                    w_state = S_IDLE;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign w_speedDiff = (i_motor_speed_sensor >= r_speed) ? (i_motor_speed_sensor - r_speed)
                                                           : (r_speed - i_motor_speed_sensor);

    assign o_motor_on  = (r_state == S_RAMP_UP) || (r_state == S_RUN) || (r_state == S_RAMP_DOWN);
    assign o_motor_dir = r_dir & ~r_spin;
    assign o_speed_cmd = r_speed;
    assign o_at_speed  = (r_state == S_RUN) && (w_speedDiff <= 10'(SPEED_TOL));
    assign o_busy      = (r_state != S_IDLE);
    assign o_fault     = (r_state == S_FAULT);

endmodule

// File: tb/tb_drum_tumble_controller.sv
// ---------------------------------------------------------------------------
// tb_drum_tumble_controller
//
// Bench for drum_tumble_controller. Instance A (TICK_DIV=1) is compared each
// cycle against a behavioural model of the drum sequence. Instance B
// (TICK_DIV=4) shares the inputs and is checked with hand-worked values.
// Directed scenarios add literal expectations at known cycles.
// ---------------------------------------------------------------------------
module tb_drum_tumble_controller;

    localparam int TDIV   = 1;
    localparam int STEP   = 10;
    localparam int TOL    = 10;
    localparam int RPAUSE = 30;
    localparam int MAXR   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [9:0] tgt;
    logic [7:0] runT;
    logic [7:0] pauseT;
    logic [9:0] sensor;
    logic       vib;

    logic       aOn, aDir, aAt, aBusy, aFault;
    logic [9:0] aSpeed;
    logic       bOn, bDir, bAt, bBusy, bFault;
    logic [9:0] bSpeed;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    drum_tumble_controller #(
        .TICK_DIV(1), .RAMP_STEP(10), .SPEED_TOL(10), .REBAL_PAUSE(30), .MAX_REBAL(3)
    ) dutA (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_mode(mode),
        .i_target_rpm(tgt), .i_run_ticks(runT), .i_pause_ticks(pauseT),
        .i_motor_speed_sensor(sensor), .i_vibration_sensor(vib),
        .o_motor_on(aOn), .o_motor_dir(aDir), .o_speed_cmd(aSpeed),
        .o_at_speed(aAt), .o_busy(aBusy), .o_fault(aFault)
    );

    drum_tumble_controller #(
        .TICK_DIV(4), .RAMP_STEP(10), .SPEED_TOL(10), .REBAL_PAUSE(30), .MAX_REBAL(3)
    ) dutB (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_mode(mode),
        .i_target_rpm(tgt), .i_run_ticks(runT), .i_pause_ticks(pauseT),
        .i_motor_speed_sensor(sensor), .i_vibration_sensor(vib),
        .o_motor_on(bOn), .o_motor_dir(bDir), .o_speed_cmd(bSpeed),
        .o_at_speed(bAt), .o_busy(bBusy), .o_fault(bFault)
    );

    // Model of the drum: which activity it is doing, how fast it is told to
    // turn, how long the current run/rest lasts and why it is slowing down.
    localparam int PH_STOPPED = 0;
    localparam int PH_ACCEL   = 1;
    localparam int PH_CRUISE  = 2;
    localparam int PH_DECEL   = 3;
    localparam int PH_REST    = 4;
    localparam int PH_TRIPPED = 5;
    localparam int W_STOP = 0;
    localparam int W_FLIP = 1;
    localparam int W_BAL  = 2;

    int mPh, mSpeed, mCnt, mDir, mVib, mWhy, mTgt, mRun, mPause, mSpin, mTick;
    bit mTickNow;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPh = PH_STOPPED; mSpeed = 0; mCnt = 0; mDir = 0; mVib = 0; mWhy = W_STOP;
            mTgt = 0; mRun = 1; mPause = 0; mSpin = 0; mTick = 0;
        end else begin
            mTickNow = (mTick == TDIV - 1);
            mTick    = mTickNow ? 0 : mTick + 1;
            case (mPh)
                PH_STOPPED: begin
                    if (en && (mode == 2'd1 || mode == 2'd2) && tgt != 10'd0) begin
                        mTgt = int'(tgt); mRun = (runT == 8'd0) ? 1 : int'(runT);
                        mPause = int'(pauseT); mSpin = (mode == 2'd2) ? 1 : 0;
                        mVib = 0; mDir = 0; mSpeed = 0; mPh = PH_ACCEL;
                    end
                end
                PH_ACCEL, PH_CRUISE: begin
                    if (!en) begin
                        mWhy = W_STOP; mPh = PH_DECEL;
                    end else if (mSpin == 1 && vib) begin
                        mVib = mVib + 1;
                        if (mVib < MAXR) begin
                            mWhy = W_BAL; mPh = PH_DECEL;
                        end else begin
                            mPh = PH_TRIPPED; mSpeed = 0;
                        end
                    end else if (mTickNow) begin
                        if (mPh == PH_ACCEL) begin
                            mSpeed = (mSpeed + STEP > mTgt) ? mTgt : mSpeed + STEP;
                            if (mSpeed == mTgt) begin
                                mPh = PH_CRUISE; mCnt = mRun;
                            end
                        end else if (mSpin == 0) begin
                            mCnt = mCnt - 1;
                            if (mCnt == 0) begin
                                mWhy = W_FLIP; mPh = PH_DECEL;
                            end
                        end
                    end
                end
                PH_DECEL: begin
                    if (!en) mWhy = W_STOP;
                    if (mTickNow) begin
                        mSpeed = (mSpeed > STEP) ? mSpeed - STEP : 0;
                        if (mSpeed == 0) begin
                            if (mWhy == W_STOP) begin
                                mPh = PH_STOPPED;
                            end else begin
                                mPh  = PH_REST;
                                mCnt = (mWhy == W_FLIP) ? mPause : RPAUSE;
                            end
                        end
                    end
                end
                PH_REST: begin
                    if (!en) begin
                        mPh = PH_STOPPED;
                    end else if (mTickNow) begin
                        mCnt = mCnt - 1;
                        if (mCnt <= 0) begin
                            if (mWhy == W_FLIP) mDir = 1 - mDir;
                            mPh = PH_ACCEL;
                        end
                    end
                end
                PH_TRIPPED: begin
                    if (!en) mPh = PH_STOPPED;
                end
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of instance A against the model.
    task automatic compareAll();
        int expOn, expAt, diff;
        expOn = (mPh == PH_ACCEL || mPh == PH_CRUISE || mPh == PH_DECEL) ? 1 : 0;
        diff  = int'(sensor) - mSpeed;
        if (diff < 0) diff = -diff;
        expAt = (mPh == PH_CRUISE && diff <= TOL) ? 1 : 0;
        checkOutput("cyc_motor_on",  int'(aOn),    expOn);
        checkOutput("cyc_motor_dir", int'(aDir),   mDir);
        checkOutput("cyc_speed_cmd", int'(aSpeed), mSpeed);
        checkOutput("cyc_at_speed",  int'(aAt),    expAt);
        checkOutput("cyc_busy",      int'(aBusy),  (mPh != PH_STOPPED) ? 1 : 0);
        checkOutput("cyc_fault",     int'(aFault), (mPh == PH_TRIPPED) ? 1 : 0);
    endtask

    // Advance n clocks, comparing on each falling edge; returns 2 time units
    // after the last rising edge, where inputs are changed.
    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compareAll();
            @(posedge clk);
        end
        #2;
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [9:0] t,
                                 input logic [7:0] r, input logic [7:0] p, input logic [9:0] s);
        en = e; mode = m; tgt = t; runT = r; pauseT = p; sensor = s;
    endtask

    // Vibration pulse from spin RUN at 50 rpm, then a full rebalance and
    // upSteps ramp ticks back up.
    task automatic rebalance(input int upSteps);
        vib = 1'b1;
        stepCycles(1);
        vib = 1'b0;
        checkOutput("rebal_start_speed", int'(aSpeed), 50);
        checkOutput("rebal_start_on",    int'(aOn), 1);
        checkOutput("rebal_no_fault",    int'(aFault), 0);
        stepCycles(5);
        checkOutput("rebal_down_speed",  int'(aSpeed), 0);
        checkOutput("rebal_pause_off",   int'(aOn), 0);
        stepCycles(29);
        checkOutput("rebal_pause_end_off", int'(aOn), 0);
        stepCycles(1);
        checkOutput("rebal_restart_on",  int'(aOn), 1);
        stepCycles(upSteps);
        checkOutput("rebal_up_speed",    int'(aSpeed), upSteps * 10);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        rst_n = 1'b0; vib = 1'b0;
        applyStimulus(1'b0, 2'd0, 10'd0, 8'd0, 8'd0, 10'd0);
        stepCycles(3);
        rst_n = 1'b1;
        stepCycles(2);
        checkOutput("reset_idle_busy",  int'(aBusy), 0);
        checkOutput("reset_idle_speed", int'(aSpeed), 0);

        // Tumble 50 rpm, run 4, pause 2; target change mid-run is ignored.
        applyStimulus(1'b1, 2'd1, 10'd50, 8'd4, 8'd2, 10'd0);
        stepCycles(3);
        checkOutput("tumble_ramp_20", int'(aSpeed), 20);
        applyStimulus(1'b1, 2'd1, 10'd90, 8'd4, 8'd2, 10'd0);
        stepCycles(3);
        checkOutput("tumble_at_50",  int'(aSpeed), 50);
        checkOutput("tumble_run_on", int'(aOn), 1);
        stepCycles(9);
        checkOutput("tumble_pause_speed", int'(aSpeed), 0);
        checkOutput("tumble_pause_off",   int'(aOn), 0);
        checkOutput("tumble_pause_busy",  int'(aBusy), 1);
        checkOutput("tumble_pause_dir",   int'(aDir), 0);
        stepCycles(2);
        checkOutput("tumble_reversed_dir", int'(aDir), 1);
        checkOutput("tumble_reramp_on",    int'(aOn), 1);
        stepCycles(5);
        checkOutput("tumble_second_50", int'(aSpeed), 50);
        stepCycles(1);

        // Asynchronous reset while running.
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_speed", int'(aSpeed), 0);
        checkOutput("async_rst_dir",   int'(aDir), 0);
        checkOutput("async_rst_on",    int'(aOn), 0);
        checkOutput("async_rst_busy",  int'(aBusy), 0);
        checkOutput("async_rst_at",    int'(aAt), 0);
        checkOutput("async_rst_fault", int'(aFault), 0);
        stepCycles(2);
        en = 1'b0;
        rst_n = 1'b1;
        stepCycles(3);
        checkOutput("post_rst_idle", int'(aBusy), 0);

        // Spin to 55: final step clamps at the target.
        applyStimulus(1'b1, 2'd2, 10'd55, 8'd0, 8'd0, 10'd0);
        stepCycles(7);
        checkOutput("spin_sat_55", int'(aSpeed), 55);
        applyStimulus(1'b1, 2'd2, 10'd55, 8'd0, 8'd0, 10'd50);
        stepCycles(1);
        checkOutput("spin_at_speed_hi", int'(aAt), 1);
        applyStimulus(1'b1, 2'd2, 10'd55, 8'd0, 8'd0, 10'd40);
        stepCycles(1);
        checkOutput("spin_at_speed_lo", int'(aAt), 0);
        checkOutput("spin_dir", int'(aDir), 0);
        applyStimulus(1'b0, 2'd2, 10'd55, 8'd0, 8'd0, 10'd0);
        stepCycles(8);
        checkOutput("spin_stopped", int'(aBusy), 0);

        // Two rebalances, then the third vibration faults.
        applyStimulus(1'b1, 2'd2, 10'd50, 8'd0, 8'd0, 10'd0);
        stepCycles(6);
        checkOutput("rebal_run_50", int'(aSpeed), 50);
        rebalance(5);
        rebalance(5);
        vib = 1'b1;
        stepCycles(1);
        vib = 1'b0;
        checkOutput("fault_set",   int'(aFault), 1);
        checkOutput("fault_speed", int'(aSpeed), 0);
        checkOutput("fault_off",   int'(aOn), 0);
        stepCycles(3);
        checkOutput("fault_held", int'(aFault), 1);
        en = 1'b0;
        stepCycles(1);
        checkOutput("fault_cleared", int'(aFault), 0);
        checkOutput("fault_to_idle", int'(aBusy), 0);
        stepCycles(2);

        // With two rebalances counted, stop plus vibration must not fault.
        applyStimulus(1'b1, 2'd2, 10'd50, 8'd0, 8'd0, 10'd0);
        stepCycles(6);
        rebalance(5);
        rebalance(3);
        en = 1'b0; vib = 1'b1;
        stepCycles(1);
        vib = 1'b0;
        checkOutput("stopvib_no_fault", int'(aFault), 0);
        checkOutput("stopvib_speed",    int'(aSpeed), 30);
        checkOutput("stopvib_on",       int'(aOn), 1);
        stepCycles(3);
        checkOutput("stopvib_speed0", int'(aSpeed), 0);
        checkOutput("stopvib_idle",   int'(aBusy), 0);

        // Tumble with zero run and zero pause.
        applyStimulus(1'b1, 2'd1, 10'd20, 8'd0, 8'd0, 10'd20);
        stepCycles(20);
        en = 1'b0;
        stepCycles(40);
        checkOutput("B_idle_before", int'(bBusy), 0);

        // Instance B: tick every 4 clocks.
        applyStimulus(1'b1, 2'd1, 10'd20, 8'd1, 8'd5, 10'd0);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            stepCycles(1);
            if (bSpeed == 10'd10) found = 1'b1;
        end
        checkOutput("B_first_step_seen", int'(found), 1);
        stepCycles(3);
        checkOutput("B_step_hold", int'(bSpeed), 10);
        stepCycles(1);
        checkOutput("B_step_next", int'(bSpeed), 20);
        checkOutput("B_run_on",    int'(bOn), 1);
        stepCycles(12);
        checkOutput("B_pause_speed", int'(bSpeed), 0);
        checkOutput("B_pause_off",   int'(bOn), 0);
        checkOutput("B_pause_busy",  int'(bBusy), 1);
        en = 1'b0;
        stepCycles(1);
        checkOutput("B_pause_abort", int'(bBusy), 0);
        checkOutput("B_dir",   int'(bDir), 0);
        checkOutput("B_at",    int'(bAt), 0);
        checkOutput("B_fault", int'(bFault), 0);

        // Requests that must not start the drum.
        applyStimulus(1'b1, 2'd1, 10'd0, 8'd3, 8'd3, 10'd0);
        stepCycles(3);
        checkOutput("zero_target_A", int'(aBusy), 0);
        checkOutput("zero_target_B", int'(bBusy), 0);
        applyStimulus(1'b1, 2'd3, 10'd50, 8'd3, 8'd3, 10'd0);
        stepCycles(3);
        checkOutput("mode11_idle", int'(aBusy), 0);
        en = 1'b0;
        stepCycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
